register_rename: RTL and testbench
==================================

REGISTER_RENAME -- requirements
Module: register_rename

Interface
REQ-001 SHALL have parameters: ARCH_REGS, default 32, number of architectural registers; PHYS_REGS, default 64, number of physical registers; FL_DEPTH, default 32, free-list depth (PHYS_REGS-ARCH_REGS).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: rename_valid  input  1  decoded instruction presented for renaming.
REQ-005 SHALL have ports: src1_arch, src2_arch, dest_arch  input  5 each  architectural source and destination registers.
REQ-006 SHALL have port: has_dest  input  1  instruction writes a register (0 for stores and branches).
REQ-007 SHALL have port: instr_pc_in  input  32  PC of the instruction being renamed.
REQ-008 SHALL have ports: retire1, retire2  input  1 each  ROB retire strobes.
REQ-009 SHALL have ports: free_reg_1, free_reg_2  input  6 each  old physical destination registers being released at retire.
REQ-010 SHALL have port: stall  output  1  rename cannot accept an instruction that needs a destination.
REQ-011 SHALL have port: out_valid  output  1  renamed instruction valid to ROB/UIQ.
REQ-012 SHALL have ports: src1_phys, src2_phys  output  6 each  physical source registers.
REQ-013 SHALL have ports: dr, old_dr  output  6 each  new and previous physical destination registers.
REQ-014 SHALL have port: instr_pc  output  32  PC passed through with the renamed instruction.
REQ-015 SHALL have port: free_count  output  6  current free-list occupancy.
REQ-016 SHALL have port: free_overflow  output  1  sticky error flag: a free arrived while the list was full.

Function
REQ-017 SHALL hold RAT[0..31] (6-bit each) plus a circular free-list FIFO of FL_DEPTH entries with 5-bit head and tail pointers and a 6-bit count.
REQ-018 stall SHALL be combinational and equal (count==0).
REQ-019 Accept condition SHALL be rename_valid && !(has_dest && dest_arch!=0 && count==0).
REQ-020 On an accepted cycle, at the next posedge: out_valid=1; src1_phys=RAT[src1_arch] and src2_phys=RAT[src2_arch], both read before this cycle's update; instr_pc=instr_pc_in.
REQ-021 Allocating accept (has_dest=1, dest_arch!=0): dr=FIFO[head]; old_dr=RAT[dest_arch]; RAT[dest_arch]<=FIFO[head]; head increments modulo FL_DEPTH.
REQ-022 Non-allocating accept (has_dest=0 or dest_arch==0): dr=0, old_dr=0, no RAT or free-list change.
REQ-023 A rejected or idle cycle SHALL register out_valid=0; other outputs hold their previous values.
REQ-024 Latency SHALL be 1 cycle, input to registered outputs; one instruction per cycle maximum.
REQ-025 Frees: each asserted retireN with free_reg_N!=0 SHALL push free_reg_N at tail. Order is retire1 first, then retire2. tail wraps modulo FL_DEPTH.
REQ-026 A free of physical register 0 SHALL be ignored, because p0 is permanently x0.
REQ-027 count SHALL update by (pushes - pops) in the same cycle; simultaneous allocate and up to two frees are all legal.
REQ-028 Allocation SHALL use the pre-edge count. A free arriving in a cycle with count==0 does not enable an allocation in that cycle.
REQ-029 A push while count==FL_DEPTH SHALL set free_overflow=1 and drop the entry. The count is evaluated sequentially across the two pushes of a cycle, net of that cycle's pop. free_overflow clears only on reset.
REQ-030 x0 SHALL always map to p0; RAT[0] is never written.

Reset
REQ-031 While rst=1, asynchronously: RAT[i]=i for i=0..31; FIFO[j]=32+j for j=0..31; head=0, tail=0, count=32; out_valid=0; src1_phys, src2_phys, dr, old_dr=0; instr_pc=0; free_overflow=0.
REQ-032 Reset asserted mid-operation SHALL discard any in-flight rename. The output in the cycle after rst deasserts is out_valid=0 unless an accept occurs.

Verification
REQ-033 After reset, rename dest_arch=5, has_dest=1, src1=5, src2=0 -> next cycle out_valid=1, dr=32, old_dr=5, src1_phys=5, src2_phys=0, free_count=31.
REQ-034 A second rename of dest x5, src1=5 -> src1_phys=32, dr=33, old_dr=32.
REQ-035 32 consecutive allocating renames -> free_count=0 and stall=1. A 33rd rename is rejected with out_valid=0. Then retire1 with free_reg_1=40 -> the next rename gets dr=40.
REQ-036 In one cycle, retire1 (free 7) and retire2 (free 9) plus one allocation with count=1 -> count=2, and FIFO order gives 7 then 9 on the next allocations.
REQ-037 Rename with dest_arch=0 or has_dest=0 -> dr=0, old_dr=0, free_count unchanged. retire1 with free_reg_1=0 -> count unchanged.
REQ-038 Free at count==32 -> free_overflow=1 and count stays 32. Then assert rst mid-stream -> all reset values of REQ-031 are restored immediately.

Source files
------------

// File: rtl/register_rename.sv
// -----------------------------------------------------------------------------
// register_rename
//   Single-issue register renamer: a RAT mapping architectural to physical
//   registers plus a circular free list of unallocated physical registers.
//   One instruction is renamed per cycle with a one-cycle registered latency;
//   up to two retiring physical registers are returned to the free list per
//   cycle (retire1 first, then retire2).
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   rename_valid              decoded instruction presented for renaming
//   src1_arch/src2_arch       architectural sources
//   dest_arch, has_dest       architectural destination and its write enable
//   instr_pc_in               PC travelling with the instruction
//   retire1/2, free_reg_1/2   released physical registers from the ROB
//   stall                     free list is empty (combinational)
//   out_valid                 renamed instruction valid (registered)
//   src1_phys/src2_phys       physical sources
//   dr, old_dr                new and previous physical destination
//   instr_pc                  PC passed through
//   free_count                free-list occupancy
//   free_overflow             sticky: a free arrived while the list was full
// -----------------------------------------------------------------------------
module register_rename #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int FL_DEPTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rename_valid,
    input  logic [$clog2(ARCH_REGS)-1:0]     src1_arch,
    input  logic [$clog2(ARCH_REGS)-1:0]     src2_arch,
    input  logic [$clog2(ARCH_REGS)-1:0]     dest_arch,
    input  logic                             has_dest,
    input  logic [31:0]                      instr_pc_in,
    input  logic                             retire1,
    input  logic                             retire2,
    input  logic [$clog2(PHYS_REGS)-1:0]     free_reg_1,
    input  logic [$clog2(PHYS_REGS)-1:0]     free_reg_2,
    output logic                             stall,
    output logic                             out_valid,
    output logic [$clog2(PHYS_REGS)-1:0]     src1_phys,
    output logic [$clog2(PHYS_REGS)-1:0]     src2_phys,
    output logic [$clog2(PHYS_REGS)-1:0]     dr,
    output logic [$clog2(PHYS_REGS)-1:0]     old_dr,
    output logic [31:0]                      instr_pc,
    output logic [$clog2(FL_DEPTH+1)-1:0]    free_count,
    output logic                             free_overflow
);

    localparam int AW = $clog2(ARCH_REGS);
    localparam int PW = $clog2(PHYS_REGS);
    localparam int TW = $clog2(FL_DEPTH);
    localparam int CW = $clog2(FL_DEPTH + 1);

    localparam logic [CW-1:0] FULL = CW'(FL_DEPTH);

    logic [PW-1:0] rat  [ARCH_REGS];
    logic [PW-1:0] fifo [FL_DEPTH];
    logic [TW-1:0] head, tail;
    logic [CW-1:0] count;

    logic          accept, alloc;
    logic [TW-1:0] head_nx, tail_nx;
    logic [CW-1:0] count_nx;
    logic          push1, push2, overflow_set;
    logic [TW-1:0] push1_idx, push2_idx;

    function automatic logic [TW-1:0] ptr_inc(input logic [TW-1:0] p);
        return (p == TW'(FL_DEPTH - 1)) ? '0 : p + TW'(1);
    endfunction

    assign stall      = (count == '0);
    assign free_count = count;

    // An instruction needing a new register is only blocked by an empty list;
    // instructions without a destination always pass.
    assign accept  = rename_valid && !(has_dest && dest_arch != '0 && count == '0);
    assign alloc   = accept && has_dest && (dest_arch != '0);
    assign head_nx = alloc ? ptr_inc(head) : head;

    // Pushes are resolved in order against a running count that already
    // includes this cycle's pop, so a full list that is also allocating can
    // still accept exactly one free.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        push1        = 1'b0;
        push2        = 1'b0;
        overflow_set = 1'b0;
        push1_idx    = tail;
        push2_idx    = tail;
        tail_nx      = tail;
        // NOTE: blocking assignments here are intentional: the running
        // tail/count values are read back later in the same evaluation.
        count_nx     = count - CW'(alloc);

        if (retire1 && free_reg_1 != '0) begin
            if (count_nx == FULL) begin
                overflow_set = 1'b1;
            end else begin
                push1     = 1'b1;
                push1_idx = tail_nx;
                tail_nx   = ptr_inc(tail_nx);
                count_nx  = count_nx + CW'(1);
            end
        end

        if (retire2 && free_reg_2 != '0) begin
            if (count_nx == FULL) begin
                overflow_set = 1'b1;
            end else begin
                push2     = 1'b1;
                push2_idx = tail_nx;
                tail_nx   = ptr_inc(tail_nx);
                count_nx  = count_nx + CW'(1);
            end
        end
    end

    // RAT and free-list storage with pointers.
    // NOTE: both arrays are reset because their initial contents (identity
    // map, registers ARCH_REGS.. in the list) are architecturally visible;
    // they are small enough to live in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) rat[i] <= PW'(i);
            for (int j = 0; j < FL_DEPTH; j++) fifo[j] <= PW'(ARCH_REGS + j);
            head          <= '0;
            tail          <= '0;
            count         <= FULL;
            free_overflow <= 1'b0;
        end else begin
            // alloc implies dest_arch != 0, so x0 stays pinned to p0.
            if (alloc) rat[dest_arch] <= fifo[head];
            if (push1) fifo[push1_idx] <= free_reg_1;
            if (push2) fifo[push2_idx] <= free_reg_2;
            head  <= head_nx;
            tail  <= tail_nx;
            count <= count_nx;
            if (overflow_set) free_overflow <= 1'b1;
        end
    end

    // Registered rename result. Sources read the RAT before this cycle's
    // update, so an instruction reading its own destination sees the old map.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            src1_phys <= '0;
            src2_phys <= '0;
            dr        <= '0;
            old_dr    <= '0;
            instr_pc  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            src1_phys <= rat[src1_arch];
            src2_phys <= rat[src2_arch];
            dr        <= alloc ? fifo[head] : '0;
            old_dr    <= alloc ? rat[dest_arch] : '0;
            instr_pc  <= instr_pc_in;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_register_rename.sv
// -----------------------------------------------------------------------------
// tb_register_rename
//   Directed scenarios for the key rename/free behaviours followed by a
//   randomized phase. Expected values come from a reference model that keeps
//   the RAT as an int array and the free list as a queue.
// -----------------------------------------------------------------------------
module tb_register_rename;

    logic        clk = 1'b0;
    logic        rst;
    logic        rename_valid;
    logic [4:0]  src1_arch, src2_arch, dest_arch;
    logic        has_dest;
    logic [31:0] instr_pc_in;
    logic        retire1, retire2;
    logic [5:0]  free_reg_1, free_reg_2;
    logic        stall, out_valid;
    logic [5:0]  src1_phys, src2_phys, dr, old_dr;
    logic [31:0] instr_pc;
    logic [5:0]  free_count;
    logic        free_overflow;

    register_rename dut (
        .clk           (clk),
        .rst           (rst),
        .rename_valid  (rename_valid),
        .src1_arch     (src1_arch),
        .src2_arch     (src2_arch),
        .dest_arch     (dest_arch),
        .has_dest      (has_dest),
        .instr_pc_in   (instr_pc_in),
        .retire1       (retire1),
        .retire2       (retire2),
        .free_reg_1    (free_reg_1),
        .free_reg_2    (free_reg_2),
        .stall         (stall),
        .out_valid     (out_valid),
        .src1_phys     (src1_phys),
        .src2_phys     (src2_phys),
        .dr            (dr),
        .old_dr        (old_dr),
        .instr_pc      (instr_pc),
        .free_count    (free_count),
        .free_overflow (free_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int m_rat [32];
    int m_fl  [$];
    bit m_ovf;
    bit e_valid;
    int e_s1, e_s2, e_dr, e_old;
    logic [31:0] e_pc;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_rat[i] = i;
        m_fl.delete();
        for (int j = 0; j < 32; j++) m_fl.push_back(32 + j);
        m_ovf   = 0;
        e_valid = 0;
        e_s1 = 0; e_s2 = 0; e_dr = 0; e_old = 0;
        e_pc = '0;
    endfunction

    function automatic void model_step(input bit rv, input bit hd, input int s1, input int s2,
                                       input int d, input logic [31:0] pc,
                                       input bit r1, input int f1, input bit r2, input int f2);
        bit needs_reg = hd && (d != 0);
        if (rv && !(needs_reg && m_fl.size() == 0)) begin
            e_valid = 1;
            e_s1    = m_rat[s1];
            e_s2    = m_rat[s2];
            e_pc    = pc;
            if (needs_reg) begin
                e_dr     = m_fl.pop_front();
                e_old    = m_rat[d];
                m_rat[d] = e_dr;
            end else begin
                e_dr  = 0;
                e_old = 0;
            end
        end else begin
            e_valid = 0;
        end
        if (r1 && f1 != 0) begin
            if (m_fl.size() == 32) m_ovf = 1;
            else m_fl.push_back(f1);
        end
        if (r2 && f2 != 0) begin
            if (m_fl.size() == 32) m_ovf = 1;
            else m_fl.push_back(f2);
        end
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".out_valid"},     32'(out_valid),     32'(e_valid));
        check({tag, ".src1_phys"},     32'(src1_phys),     32'(e_s1));
        check({tag, ".src2_phys"},     32'(src2_phys),     32'(e_s2));
        check({tag, ".dr"},            32'(dr),            32'(e_dr));
        check({tag, ".old_dr"},        32'(old_dr),        32'(e_old));
        check({tag, ".instr_pc"},      instr_pc,           e_pc);
        check({tag, ".free_count"},    32'(free_count),    32'(m_fl.size()));
        check({tag, ".stall"},         32'(stall),         32'(m_fl.size() == 0));
        check({tag, ".free_overflow"}, 32'(free_overflow), 32'(m_ovf));
    endtask

    task automatic drive_idle();
        rename_valid = 0; has_dest = 0;
        src1_arch = '0; src2_arch = '0; dest_arch = '0;
        instr_pc_in = '0;
        retire1 = 0; retire2 = 0; free_reg_1 = '0; free_reg_2 = '0;
    endtask

    // Drive one cycle of stimulus (called just after a rising edge), advance
    // the model, then compare everything 1 time unit after the next edge.
    task automatic do_cycle(input string tag, input bit rv, input bit hd, input int s1, input int s2,
                            input int d, input bit r1, input int f1, input bit r2, input int f2);
        logic [31:0] pc = $urandom;
        rename_valid = rv; has_dest = hd;
        src1_arch = 5'(s1); src2_arch = 5'(s2); dest_arch = 5'(d);
        instr_pc_in = pc;
        retire1 = r1; retire2 = r2; free_reg_1 = 6'(f1); free_reg_2 = 6'(f2);
        model_step(rv, hd, s1, s2, d, pc, r1, f1, r2, f2);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic rename(input string tag, input int d, input int s1, input int s2);
        do_cycle(tag, 1, 1, s1, s2, d, 0, 0, 0, 0);
    endtask

    initial begin
        drive_idle();
        rst = 1;
        model_reset();
        #1;
        check_all("reset_async");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        do_cycle("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // First allocation and a dependent second one.
        rename("first", 5, 5, 0);
        check("first.dr_lit",     32'(dr),         32'd32);
        check("first.old_lit",    32'(old_dr),     32'd5);
        check("first.src1_lit",   32'(src1_phys),  32'd5);
        check("first.count_lit",  32'(free_count), 32'd31);
        rename("second", 5, 5, 0);
        check("second.src1_lit",  32'(src1_phys),  32'd32);
        check("second.dr_lit",    32'(dr),         32'd33);
        check("second.old_lit",   32'(old_dr),     32'd32);

        // Drain the free list.
        for (int i = 0; i < 30; i++)
            rename("drain", $urandom_range(1, 31), $urandom_range(0, 31), $urandom_range(0, 31));
        check("drain.stall_lit", 32'(stall),      32'd1);
        check("drain.count_lit", 32'(free_count), 32'd0);

        // Rename at empty with a free in the same cycle: still rejected.
        do_cycle("empty_rej", 1, 1, 1, 2, 7, 1, 40, 0, 0);
        check("empty_rej.valid_lit", 32'(out_valid), 32'd0);
        rename("reuse40", 3, 1, 2);
        check("reuse40.dr_lit", 32'(dr), 32'd40);

        // Two frees plus an allocation with one entry left.
        do_cycle("prime", 0, 0, 0, 0, 0, 1, 50, 0, 0);
        do_cycle("dual", 1, 1, 4, 4, 4, 1, 7, 1, 9);
        check("dual.dr_lit",    32'(dr),         32'd50);
        check("dual.count_lit", 32'(free_count), 32'd2);
        rename("order1", 6, 0, 0);
        check("order1.dr_lit", 32'(dr), 32'd7);
        rename("order2", 8, 0, 0);
        check("order2.dr_lit", 32'(dr), 32'd9);

        // Non-allocating renames pass even when stalled; free of p0 ignored.
        do_cycle("dest_x0", 1, 1, 6, 8, 0, 0, 0, 0, 0);
        check("dest_x0.valid_lit", 32'(out_valid), 32'd1);
        do_cycle("no_dest", 1, 0, 8, 6, 3, 0, 0, 0, 0);
        do_cycle("free_p0", 0, 0, 0, 0, 0, 1, 0, 1, 0);
        check("free_p0.count_lit", 32'(free_count), 32'd0);

        // Refill to full, then overflow.
        for (int i = 0; i < 16; i++)
            do_cycle("refill", 0, 0, 0, 0, 0, 1, $urandom_range(1, 63), 1, $urandom_range(1, 63));
        check("refill.ovf_lit", 32'(free_overflow), 32'd0);
        do_cycle("ovf", 0, 0, 0, 0, 0, 1, 11, 0, 0);
        check("ovf.flag_lit",  32'(free_overflow), 32'd1);
        check("ovf.count_lit", 32'(free_count),    32'd32);
        // Full list, allocating: first free fits, second overflows.
        do_cycle("ovf_pop", 1, 1, 2, 3, 12, 1, 13, 1, 14);

        // Asynchronous reset in the middle of a cycle with a rename pending.
        rename_valid = 1; has_dest = 1; dest_arch = 5'd9; retire1 = 1; free_reg_1 = 6'd20;
        #2;
        rst = 1;
        model_reset();
        #1;
        check_all("mid_rst");
        drive_idle();
        @(posedge clk); #1;
        rst = 0;
        do_cycle("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rename("post_rst_ren", 5, 5, 0);
        check("post_rst_ren.dr_lit", 32'(dr), 32'd32);

        // Randomized phase: retire pressure changes per block so the list
        // wanders between empty and full.
        for (int blk = 0; blk < 20; blk++) begin
            int p = $urandom_range(0, 100);
            for (int i = 0; i < 100; i++) begin
                do_cycle("rand",
                         $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                         $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                         $urandom_range(0, 99) < p, $urandom_range(0, 63),
                         $urandom_range(0, 99) < p, $urandom_range(0, 63));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
